// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: owns acc/flags and sequences an external 8-bit ALU.
// Define ALU_SEQ_MUL_EN to enable the 16-cycle shift-add multiply (op 111).
module alu_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  output logic [1:0]       alu_ls,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_zout,
  output logic [WIDTH-1:0] acc,
  output logic             c_flag,
  output logic             z_flag,
  output logic             busy,
  output logic             done
);

  if (CNT_W != $clog2(WIDTH)) begin : g_cnt_w_chk
    $error("CNT_W must equal log2(WIDTH)");
  end

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] SEL_NUL = 2'b00;
  localparam logic [1:0] SEL_NOR = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;
  localparam logic [1:0] SEL_SUB = 2'b11;

  localparam logic [1:0] LS_RST = 2'b00;
  localparam logic [1:0] LS_SHL = 2'b01;
  localparam logic [1:0] LS_LD  = 2'b10;
  localparam logic [1:0] LS_SHR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
`ifdef ALU_SEQ_MUL_EN
    S_MUL_ADD,
    S_MUL_SHL,
`endif
    S_DONE
  } state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] opr_q;
  logic [WIDTH-1:0] acc_q;
  logic             c_q;
  logic             z_q;
  logic             busy_q;
  logic             ready_q;
  logic             done_q;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sticky_q;
  logic             zmul_q;
  logic             sticky_d;
  logic             last_iter;

  // A bit shifted out of M is lost product only if Q still has work left
  assign sticky_d  = sticky_q | (m_q[WIDTH-1] & (|q_q[WIDTH-1:1]));
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  assign acc       = acc_q;
  assign c_flag    = c_q;
  assign z_flag    = z_q;
  assign busy      = busy_q;
  assign cmd_ready = ready_q;
  assign done      = done_q;

  always_comb begin
    alu_a   = acc_q;
    alu_b   = '0;
    alu_sel = SEL_NUL;
    alu_ls  = LS_LD;
    case (state_q)
      S_EXEC: begin
        alu_b = opr_q;
        unique case (op_q)
          OP_CLR: alu_ls = LS_RST;
          OP_LD:  alu_a = opr_q;
          OP_ADD: alu_sel = SEL_ADD;
          OP_SUB: alu_sel = SEL_SUB;
          OP_NOR: alu_sel = SEL_NOR;
          OP_SHL: alu_ls = LS_SHL;
          OP_SHR: alu_ls = LS_SHR;
          OP_MUL: alu_b = '0;
        endcase
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL_ADD: begin
        alu_a   = p_q;
        alu_b   = q_q[0] ? m_q : '0;
        alu_sel = SEL_ADD;
      end
      S_MUL_SHL: begin
        alu_a  = m_q;
        alu_ls = LS_SHL;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opr_q    <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      p_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      zmul_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && ready_q) begin
            op_q    <= cmd_op;
            opr_q   <= cmd_data;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_EXEC;
`ifdef ALU_SEQ_MUL_EN
            if (cmd_op == OP_MUL) begin
              p_q      <= '0;
              m_q      <= acc_q;
              q_q      <= cmd_data;
              cnt_q    <= '0;
              sticky_q <= 1'b0;
              state_q  <= S_MUL_ADD;
            end
`endif
          end
        end
        S_EXEC: begin
          if (op_q != OP_MUL) begin
            acc_q <= alu_result;
            c_q   <= alu_cout;
            z_q   <= alu_zout;
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL_ADD: begin
          p_q      <= alu_result;
          sticky_q <= sticky_q | alu_cout;
          if (last_iter) zmul_q <= alu_zout;
          state_q  <= S_MUL_SHL;
        end
        S_MUL_SHL: begin
          m_q      <= alu_result;
          q_q      <= q_q >> 1;
          sticky_q <= sticky_d;
          if (last_iter) begin
            // Flags are held back so acc/c/z all change on one edge
            acc_q   <= p_q;
            c_q     <= sticky_d;
            z_q     <= zmul_q;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= S_MUL_ADD;
          end
        end
`endif
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: table + scoreboard bench for alu_seq_ctrl with an ALU model.
// Expected MUL results follow ALU_SEQ_MUL_EN when defined for the build.
module tb_alu_seq_ctrl;

  localparam logic [2:0] CLR = 3'b000;
  localparam logic [2:0] LD  = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] NOR = 3'b100;
  localparam logic [2:0] SHL = 3'b101;
  localparam logic [2:0] SHR = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
  localparam int LAT_M  = 17;
`else
  localparam bit MUL_ON = 1'b0;
  localparam int LAT_M  = 2;
`endif
  localparam int LAT_S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_sel, alu_ls;
  logic       alu_cout, alu_zout;
  logic [7:0] acc;
  logic       c_flag, z_flag, busy, done;

  alu_seq_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_ls(alu_ls),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_zout(alu_zout),
    .acc(acc), .c_flag(c_flag), .z_flag(z_flag),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ALU model: sel != 00 is arithmetic, otherwise load_shift picks the op
  always_comb begin
    alu_result = 8'h00;
    alu_cout   = 1'b0;
    case (alu_sel)
      2'b10: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b11: begin
        alu_result = alu_a - alu_b;
        alu_cout   = (alu_a < alu_b);
      end
      2'b01: alu_result = ~(alu_a | alu_b);
      default: begin
        case (alu_ls)
          2'b01: {alu_cout, alu_result} = {alu_a, 1'b0};
          2'b11: {alu_result, alu_cout} = {1'b0, alu_a};
          2'b10: alu_result = alu_a;
          default: alu_result = 8'h00;
        endcase
      end
    endcase
    alu_zout = (alu_result == 8'h00);
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] acc;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] acc;
    logic       c;
    logic       z;
    int         lat;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input int act, input int expv);
    nchk++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic add(input logic [2:0] op, input logic [7:0] d,
                     input logic [7:0] a, input logic c, input logic z);
    vec_t v;
    v.op = op; v.data = d; v.acc = a; v.c = c; v.z = z;
    v.lat = (op == MUL) ? LAT_M : LAT_S;
    tbl.push_back(v);
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.acc = v.acc; e.c = v.c; e.z = v.z; e.lat = v.lat;
    sb.push_back(e);
  endtask

  // Drives a command and returns #1 after the accepting edge
  task automatic send(input logic [2:0] op, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_cmd();
    int         n = 0;
    bit         stable = 1'b1;
    logic [7:0] a0 = acc;
    logic       c0 = c_flag;
    logic       z0 = z_flag;
    exp_t       e;
    while (!done && n < 40) begin
      if (acc != a0 || c_flag != c0 || z_flag != z0) stable = 1'b0;
      if (!busy || cmd_ready) stable = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk("stable_busy", int'(stable), 1);
    chk("ready_in_done", int'(cmd_ready), 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("latency", n + 1, e.lat);
      chk("acc", int'(acc), int'(e.acc));
      chk("c_flag", int'(c_flag), int'(e.c));
      chk("z_flag", int'(z_flag), int'(e.z));
    end
    @(posedge clk);
    #1;
    chk("done_pulse", int'(done), 0);
    chk("ready_after", int'(cmd_ready), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit   saw_done;

    add(LD,  8'h5A, 8'h5A, 0, 0);
    add(LD,  8'hF0, 8'hF0, 0, 0);
    add(ADD, 8'hC0, 8'hB0, 1, 0);
    add(SUB, 8'hB0, 8'h00, 0, 1);
    add(LD,  8'h05, 8'h05, 0, 0);
    add(SUB, 8'h07, 8'hFE, 1, 0);
    add(LD,  8'h0D, 8'h0D, 0, 0);
    add(MUL, 8'h0B, MUL_ON ? 8'h8F : 8'h0D, 0, 0);
    add(LD,  8'h10, 8'h10, 0, 0);
    add(MUL, 8'h10, MUL_ON ? 8'h00 : 8'h10, MUL_ON, MUL_ON);
    add(LD,  8'hFF, 8'hFF, 0, 0);
    add(MUL, 8'hFF, MUL_ON ? 8'h01 : 8'hFF, MUL_ON, 0);
    add(LD,  8'h80, 8'h80, 0, 0);
    add(MUL, 8'h02, MUL_ON ? 8'h00 : 8'h80, MUL_ON, MUL_ON);
    add(LD,  8'h80, 8'h80, 0, 0);
    add(MUL, 8'h01, 8'h80, 0, 0);
    add(LD,  8'h37, 8'h37, 0, 0);
    add(MUL, 8'h00, MUL_ON ? 8'h00 : 8'h37, 0, MUL_ON);
    add(LD,  8'h81, 8'h81, 0, 0);
    add(SHL, 8'h00, 8'h02, 1, 0);
    add(SHR, 8'h00, 8'h01, 0, 0);
    add(LD,  8'h81, 8'h81, 0, 0);
    add(NOR, 8'h7E, 8'h00, 0, 1);
    add(LD,  8'hFF, 8'hFF, 0, 0);
    add(ADD, 8'h01, 8'h00, 1, 1);
    add(LD,  8'h81, 8'h81, 0, 0);
    add(CLR, 8'h55, 8'h00, 0, 1);
    add(LD,  8'h00, 8'h00, 0, 1);

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", int'(acc), 0);
    chk("rst_c", int'(c_flag), 0);
    chk("rst_z", int'(z_flag), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      send(v.op, v.data);
      push_exp(v);
      finish_cmd();
    end

    // Held command while busy: accepted only once back in IDLE
    send(LD, 8'h0D);
    push_exp('{LD, 8'h0D, 8'h0D, 1'b0, 1'b0, LAT_S});
    finish_cmd();
    send(MUL, 8'h0B);
    cmd_valid = 1'b1;
    cmd_op    = LD;
    cmd_data  = 8'h77;
    push_exp('{MUL, 8'h0B, MUL_ON ? 8'h8F : 8'h0D, 1'b0, 1'b0, LAT_M});
    finish_cmd();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("held_accept", int'(busy), 1);
    push_exp('{LD, 8'h77, 8'h77, 1'b0, 1'b0, LAT_S});
    finish_cmd();

    // Reset in the middle of a command
    send(LD, 8'h0D);
    push_exp('{LD, 8'h0D, 8'h0D, 1'b0, 1'b0, LAT_S});
    finish_cmd();
`ifdef ALU_SEQ_MUL_EN
    send(MUL, 8'h0B);
    repeat (8) @(posedge clk);
`else
    send(LD, 8'h55);
`endif
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_acc", int'(acc), 0);
    chk("mid_rst_c", int'(c_flag), 0);
    chk("mid_rst_z", int'(z_flag), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_abort", int'(saw_done), 0);
    chk("idle_after_abort", int'(busy), 0);
    send(LD, 8'h33);
    push_exp('{LD, 8'h33, 8'h33, 1'b0, 1'b0, LAT_S});
    finish_cmd();

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
